// File: rtl/ldpc_pkg.sv
// Shared constants for the LDPC hard-decision / syndrome stage: code geometry,
// the parity-check matrix stored column-wise, and the control FSM encoding.
package ldpc_pkg;

  localparam int N        = 8;
  localparam int M        = 4;
  localparam int WIDTH    = 8;
  localparam int MAX_ITER = 10;
  localparam int ITER_W   = 7;

  // Column j of H as an M-bit mask. A 1 in bit j of the codeword flips every
  // parity check whose row bit is set in H_COL[j].
  localparam logic [M-1:0] H_COL [N] = '{
    4'b0011, 4'b0101, 4'b1001, 4'b0110,
    4'b1010, 4'b1100, 4'b0111, 4'b1110
  };

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_CHECK   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/ldpc_syndrome_acc.sv
// Running syndrome accumulator: XORs in the H column of every hard-decided 1.
// A clear together with enable restarts the syndrome from the current sample.
module ldpc_syndrome_acc #(
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         xrst,
  input  logic         clear,
  input  logic         enable,
  input  logic         hard_bit,
  input  logic [M-1:0] col,
  output logic [M-1:0] syn
);

  logic [M-1:0] contrib;

  assign contrib = hard_bit ? col : '0;

  // Accumulate on each accepted sample; clear drops any partial syndrome.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      syn <= '0;
    end else if (enable) begin
      syn <= (clear ? '0 : syn) ^ contrib;
    end else if (clear) begin
      syn <= '0;
    end
  end

endmodule

// File: rtl/ldpc_decision.sv
// Hard-decision and syndrome check for one LDPC frame of N posterior LLRs.
// Collects N samples (gaps allowed), then checks the syndrome and issues a
// pass/stop decision two cycles after the last sample is accepted.
module ldpc_decision
  import ldpc_pkg::*;
#(
  parameter int N        = ldpc_pkg::N,
  parameter int M        = ldpc_pkg::M,
  parameter int WIDTH    = ldpc_pkg::WIDTH,
  parameter int MAX_ITER = ldpc_pkg::MAX_ITER
) (
  input  logic             clk,
  input  logic             xrst,
  input  logic             i_val,
  input  logic             i_first,
  input  logic [WIDTH-1:0] i_data,
  input  logic [6:0]       i_iter,
  output logic [N-1:0]     o_data,
  output logic             o_val,
  output logic             o_pass,
  output logic             o_stop,
  output logic             o_err
);

  localparam int                       IDX_W      = $clog2(N);
  localparam logic [IDX_W-1:0]         LAST_IDX   = IDX_W'(N - 1);
  localparam logic [6:0]               ITER_LIMIT = 7'(MAX_ITER);
  localparam logic signed [WIDTH-1:0]  LLR_ZERO   = '0;

  state_t state, state_nxt;

  logic [IDX_W-1:0]         idx;
  logic [IDX_W-1:0]         wr_idx;
  logic [6:0]               iter_lat;
  logic [N-1:0]             bits;
  logic [M-1:0]             syn;
  logic [M-1:0]             col;
  logic signed [WIDTH-1:0]  llr;
  logic                     hard_bit;
  logic                     start;
  logic                     take;
  logic                     check;
  logic                     err;

  logic                     vld_p0;
  logic [N-1:0]             data_p0;
  logic                     pass_p0;
  logic                     stop_p0;

  assign llr      = i_data;
  assign hard_bit = (llr < LLR_ZERO);
  assign wr_idx   = start ? '0 : idx;
  assign col      = H_COL[wr_idx];

  // State register.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    take      = 1'b0;
    check     = 1'b0;
    err       = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (i_val) begin
          if (i_first) begin
            start     = 1'b1;
            state_nxt = ST_COLLECT;
          end else begin
            err = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (i_val) begin
          if (i_first) begin
            start = 1'b1;
            err   = 1'b1;
          end else begin
            take = 1'b1;
            if (idx == LAST_IDX) begin
              state_nxt = ST_CHECK;
            end
          end
        end
      end
      ST_CHECK: begin
        check     = 1'b1;
        err       = i_val;
        state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Sample index and iteration count latched with sample 0.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      idx      <= '0;
      iter_lat <= '0;
    end else if (start) begin
      idx      <= IDX_W'(1);
      iter_lat <= i_iter;
    end else if (take && (idx != LAST_IDX)) begin
      idx <= idx + 1'b1;
    end
  end

  // Hard-decision bits, bit j written by sample j; a restart clears the rest.
  always_ff @(posedge clk) begin
    if (start) begin
      bits <= N'(hard_bit);
    end else if (take) begin
      bits[idx] <= hard_bit;
    end
  end

  ldpc_syndrome_acc #(
    .M (M)
  ) u_syn (
    .clk      (clk),
    .xrst     (xrst),
    .clear    (start),
    .enable   (start | take),
    .hard_bit (hard_bit),
    .col      (col),
    .syn      (syn)
  );

  // ---- stage p0: syndrome decision taken in CHECK ----
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= check;
    end
  end

  // Decision data for stage p0.
  always_ff @(posedge clk) begin
    if (check) begin
      data_p0 <= bits;
      pass_p0 <= (syn == '0);
      stop_p0 <= (syn == '0) | (iter_lat >= ITER_LIMIT);
    end
  end

  // ---- output stage: results held until the next decision ----
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      o_val  <= 1'b0;
      o_data <= '0;
      o_pass <= 1'b0;
      o_stop <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      o_val <= vld_p0;
      o_err <= err;
      if (vld_p0) begin
        o_data <= data_p0;
        o_pass <= pass_p0;
        o_stop <= stop_p0;
      end
    end
  end

endmodule

// File: tb/tb_ldpc_decision.sv
// Scoreboard bench for ldpc_decision: frames are driven sample by sample,
// expected decisions are queued at the last sample and compared on o_val.
module tb_ldpc_decision;
  import ldpc_pkg::*;

  typedef logic signed [7:0] llr_t;
  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       xrst;
  logic       i_val;
  logic       i_first;
  logic [7:0] i_data;
  logic [6:0] i_iter;
  logic [7:0] o_data;
  logic       o_val;
  logic       o_pass;
  logic       o_stop;
  logic       o_err;

  int   vectors = 0;
  int   miscompares = 0;
  int   err_cnt = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  exp_t q[$];
  exp_t last_exp;

  ldpc_decision dut (
    .clk     (clk),
    .xrst    (xrst),
    .i_val   (i_val),
    .i_first (i_first),
    .i_data  (i_data),
    .i_iter  (i_iter),
    .o_data  (o_data),
    .o_val   (o_val),
    .o_pass  (o_pass),
    .o_stop  (o_stop),
    .o_err   (o_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input llr_t f[8], input int iter);
    exp_t       e;
    logic [3:0] s;
    e.d = '0;
    s   = '0;
    for (int j = 0; j < 8; j++) begin
      if (f[j] < 0) begin
        e.d[j] = 1'b1;
        s      = s ^ H_COL[j];
      end
    end
    e.p   = (s == 4'd0);
    e.s   = e.p || (iter >= 10);
    e.cyc = 0;
    return e;
  endfunction

  // Decision monitor: compare every o_val against the oldest queued frame.
  always @(negedge clk) begin
    exp_t e;
    if (o_err) err_cnt++;
    if (xrst && o_val) begin
      if (q.size() == 0) begin
        chk("unexpected_o_val", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("o_data", 32'(o_data), 32'(e.d));
        chk("o_pass", 32'(o_pass), 32'(e.p));
        chk("o_stop", 32'(o_stop), 32'(e.s));
        chk("latency", 32'(cyc - e.cyc), 32'd2);
        last_exp = e;
      end
    end
  end

  task automatic put(input logic first, input llr_t v, input int iter);
    @(negedge clk);
    i_val   = 1'b1;
    i_first = first;
    i_data  = v;
    i_iter  = 7'(iter);
    @(posedge clk);
    #1;
    last_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_val   = 1'b0;
      i_first = 1'b0;
    end
  endtask

  task automatic send_frame(input llr_t f[8], input int iter, input int maxgap);
    exp_t e;
    for (int j = 0; j < 8; j++) begin
      if (maxgap > 0) idle(int'($urandom_range(0, maxgap)));
      put(j == 0, f[j], iter);
    end
    e     = model(f, iter);
    e.cyc = last_cyc;
    q.push_back(e);
  endtask

  task automatic codeword_frame(input logic [7:0] cw, output llr_t f[8]);
    for (int j = 0; j < 8; j++) begin
      if (cw[j]) f[j] = llr_t'(-1 - int'($urandom_range(0, 30)));
      else       f[j] = llr_t'(int'($urandom_range(0, 30)));
    end
  endtask

  initial begin
    llr_t f[8];
    int   e0;

    xrst = 1'b1; i_val = 1'b0; i_first = 1'b0; i_data = '0; i_iter = '0;
    #2 xrst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_o_val",  32'(o_val),  32'd0);
    chk("rst_o_data", 32'(o_data), 32'd0);
    chk("rst_o_pass", 32'(o_pass), 32'd0);
    chk("rst_o_stop", 32'(o_stop), 32'd0);
    chk("rst_o_err",  32'(o_err),  32'd0);
    xrst = 1'b1;
    idle(2);

    // All +5, iteration 3: clean codeword.
    for (int j = 0; j < 8; j++) f[j] = 8'sd5;
    send_frame(f, 3, 0);
    idle(6);
    chk("hold_o_data", 32'(o_data), 32'(last_exp.d));
    chk("hold_o_pass", 32'(o_pass), 32'(last_exp.p));
    chk("hold_o_val",  32'(o_val),  32'd0);

    // Single negative LLR at bit 3: syndrome non-zero.
    f[3] = -8'sd7;
    send_frame(f, 3, 0);
    idle(4);
    send_frame(f, 10, 0);
    idle(4);

    // Null-space codewords with random gaps.
    codeword_frame(8'h0B, f);
    send_frame(f, 2, 3);
    idle(4);
    codeword_frame(8'h15, f);
    send_frame(f, 12, 3);
    idle(4);

    // Random frames, including zero LLRs and iteration limit edges.
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < 8; j++) f[j] = llr_t'(int'($urandom_range(0, 40)) - 20);
      send_frame(f, 8 + k, k % 4);
      idle(3);
    end

    // Restart: i_first at sample 5 aborts the partial frame.
    e0 = err_cnt;
    for (int j = 0; j < 5; j++) put(j == 0, -8'sd3, 4);
    for (int j = 0; j < 8; j++) f[j] = llr_t'(int'($urandom_range(0, 40)) - 20);
    send_frame(f, 4, 0);
    idle(4);
    chk("restart_err", 32'(err_cnt - e0), 32'd1);

    // Stray samples during CHECK and in DONE are rejected.
    e0 = err_cnt;
    codeword_frame(8'h0B, f);
    send_frame(f, 1, 0);
    put(1'b0, 8'sd9, 1);
    idle(3);
    put(1'b0, -8'sd9, 1);
    idle(4);
    chk("stray_err", 32'(err_cnt - e0), 32'd2);

    // Reset after sample 4 discards the frame.
    for (int j = 0; j < 5; j++) put(j == 0, -8'sd2, 5);
    @(negedge clk);
    i_val = 1'b0; i_first = 1'b0;
    xrst  = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_o_val",  32'(o_val),  32'd0);
    chk("mid_rst_o_data", 32'(o_data), 32'd0);
    chk("mid_rst_o_pass", 32'(o_pass), 32'd0);
    chk("mid_rst_o_stop", 32'(o_stop), 32'd0);
    xrst = 1'b1;
    idle(2);
    e0 = err_cnt;
    put(1'b0, -8'sd4, 5);
    idle(6);
    chk("post_rst_no_val", 32'(q.size()), 32'd0);
    for (int j = 0; j < 8; j++) f[j] = llr_t'(int'($urandom_range(0, 40)) - 20);
    send_frame(f, 5, 2);
    idle(5);
    chk("post_rst_err", 32'(err_cnt - e0), 32'd1);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ldpc_decision.md
LDPC_DECISION -- requirements
Module: ldpc_decision

Interface
REQ-001 Parameter N, default 8: code length, i.e. number of posterior LLRs per frame.
REQ-002 Parameter M, default 4: number of parity checks (rows of H).
REQ-003 Parameter WIDTH, default 8: LLR width, two's complement.
REQ-004 Parameter MAX_ITER, default 10: iteration limit; a value of 10 forces stop.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 xrst  input  1  reset, asynchronous, active-low.
REQ-007 i_val  input  1  qualifies i_data, i_first, i_iter.
REQ-008 i_first  input  1  marks bit index 0 of a frame.
REQ-009 i_data  input  WIDTH  signed posterior LLR (lambda + sum of betas) of the current bit.
REQ-010 i_iter  input  7  iteration count from the decoder controller (its loop counter).
REQ-011 o_data  output  N  hard-decision codeword, bit j = decision of the j-th sample.
REQ-012 o_val  output  1  one-cycle pulse; o_data, o_pass and o_stop are valid.
REQ-013 o_pass  output  1  1 = syndrome all-zero.
REQ-014 o_stop  output  1  1 = controller terminates decoding.
REQ-015 o_err  output  1  one-cycle pulse on a framing error.

Function
REQ-016 States are IDLE, COLLECT, CHECK and DONE; the state register is 2 bits.
REQ-017 Hard decision: bit = MSB of i_data, so a negative LLR gives 1 and an LLR of zero or more gives 0.
REQ-018 IDLE: i_val&i_first accepts sample 0 -> COLLECT, idx=1; i_val without i_first is ignored and pulses o_err.
REQ-019 COLLECT: each i_val sample j stores its bit in shift register position j and updates syn ^= bit ? H_COL[j] : 0 (M bits).
REQ-020 Gaps (i_val=0) hold all state, with no timeout.
REQ-021 When sample N-1 is accepted -> CHECK; idx does not wrap past N-1.
REQ-022 i_first in COLLECT restarts the frame: o_err pulses, syn and bits restart from this sample, idx=1.
REQ-023 CHECK: a single cycle; o_pass = (syn==0), o_stop = o_pass | (i_iter_latched >= MAX_ITER), and o_val=1 -> DONE.
REQ-024 i_iter is latched with sample 0 of each frame.
REQ-025 Latency: o_val is asserted exactly 2 cycles after the rising edge that accepts sample N-1.
REQ-026 DONE: o_data, o_pass and o_stop hold until the next i_first; o_val stays 0.
REQ-027 In DONE, i_val&i_first starts a new frame (as in IDLE); other samples are ignored with an o_err pulse.
REQ-028 Inputs are ignored during CHECK (the controller never sends then); any i_val in CHECK pulses o_err.
REQ-029 If sample N-1 and i_first arrive together, the i_first rule (REQ-022) takes priority.

Reset
REQ-030 On xrst=0: state=IDLE, idx=0, syn=0, o_data=0, o_val=0, o_pass=0, o_stop=0, o_err=0.
REQ-031 Reset mid-frame discards all partial syndrome and bit state; no o_val is issued for that frame.
REQ-032 After reset is released, the first frame needs i_first.

Structure
REQ-033 Shared package ldpc_pkg holds the H_COL[N] array of M-bit column masks, WIDTH, N, M and MAX_ITER; these are shared with the row, column and control stages.
REQ-034 A single sub-module ldpc_syndrome_acc (clear, enable, bit, column mask -> syn) implements REQ-019.
REQ-035 The RTL is no larger than about 250 lines; it contains no memory macros.

Verification
REQ-036 Frame with all eight LLRs = +5 and i_iter=3 -> o_data=8'h00, o_pass=1, o_stop=1, o_val 2 cycles after the last sample.
REQ-037 Only bit 3 LLR = -7 (H_COL[3]!=0) with i_iter=3 -> o_data=8'h08, o_pass=0, o_stop=0.
REQ-038 Same failing frame with i_iter=10 -> o_pass=0, o_stop=1.
REQ-039 Random 0-3 cycle i_val gaps plus a codeword from H's null space -> o_pass=1, and o_data equals the codeword.
REQ-040 i_first re-asserted at sample 5 -> o_err pulse, then a full 8-sample frame is decoded correctly.
REQ-041 xrst pulsed after sample 4 -> no o_val, all outputs 0; the next complete frame decodes correctly.
